// File: rtl/soda_vend_n_if.sv
// Coin front end / vend controller signal bundle.
// The master side presents coins and cancel; the slave side is the controller.
interface soda_vend_n_if #(
  parameter int CREDIT_W = 7,
  parameter int CNT_W    = 8
);
  logic                nickle_i;
  logic                dime_i;
  logic                quater_i;
  logic                cancel_i;
  logic                soda_o;
  logic                change_o;
  logic                reject_o;
  logic                busy_o;
  logic [CREDIT_W-1:0] credit_o;
  logic [CNT_W-1:0]    sold_cnt_o;

  modport master (
    output nickle_i, dime_i, quater_i, cancel_i,
    input  soda_o, change_o, reject_o, busy_o, credit_o, sold_cnt_o
  );

  modport slave (
    input  nickle_i, dime_i, quater_i, cancel_i,
    output soda_o, change_o, reject_o, busy_o, credit_o, sold_cnt_o
  );
endinterface

// File: rtl/soda_vend_n.sv
// Parametrised coin-operated vending controller: credits coins, vends once at PRICE,
// then returns any excess credit one nickel per cycle.
module soda_vend_n #(
  parameter int PRICE      = 20,
  parameter int MAX_CREDIT = 60,
  parameter int CREDIT_W   = 7,
  parameter int CNT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  soda_vend_n_if.slave bus
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W:0]   PRICE_S   = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_S     = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CNT_W-1:0]    sold_cnt_reg, sold_cnt_next;
  logic                soda_reg, soda_next;
  logic                change_reg, change_next;
  logic                reject_reg, reject_next;
  logic                busy_reg, busy_next;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_sel;
  logic                coin_extra;
  logic                coin_any;
  logic                coin_fits;
  logic                cancel_go;

  // Priority coin pick: only the winner is evaluated, losers are always rejected.
  always_comb begin
    coin_val   = '0;
    coin_extra = 1'b0;
    coin_any   = bus.nickle_i | bus.dime_i | bus.quater_i;
    coin_sel   = coin_any;
    if (bus.nickle_i) begin
      coin_val   = (CREDIT_W+1)'(5);
      coin_extra = bus.dime_i | bus.quater_i;
    end else if (bus.dime_i) begin
      coin_val   = (CREDIT_W+1)'(10);
      coin_extra = bus.quater_i;
    end else if (bus.quater_i) begin
      coin_val   = (CREDIT_W+1)'(25);
    end
    credit_sum = {1'b0, credit_reg} + coin_val;
    coin_fits  = (credit_sum <= MAX_S);
    cancel_go  = bus.cancel_i && (credit_reg != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: begin
        if (cancel_go) begin
          state_next = ST_CHANGE;
        end else if (coin_sel && coin_fits && (credit_sum >= PRICE_S)) begin
          state_next = ST_VEND;
        end
      end
      ST_VEND: begin
        state_next = (credit_reg != PRICE_C) ? ST_CHANGE : ST_COLLECT;
      end
      ST_CHANGE: begin
        if (credit_reg == NICKEL_C) begin
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  // Datapath and registered outputs; pulse outputs follow the state being entered.
  always_comb begin
    credit_next   = credit_reg;
    sold_cnt_next = sold_cnt_reg;
    reject_next   = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        if (cancel_go) begin
          reject_next = coin_any;
        end else if (coin_sel) begin
          if (coin_fits) begin
            credit_next = credit_sum[CREDIT_W-1:0];
          end
          reject_next = coin_extra | ~coin_fits;
        end
      end
      ST_VEND: begin
        credit_next   = credit_reg - PRICE_C;
        sold_cnt_next = sold_cnt_reg + CNT_W'(1);
        reject_next   = coin_any;
      end
      ST_CHANGE: begin
        credit_next = credit_reg - NICKEL_C;
        reject_next = coin_any;
      end
      default: begin
        credit_next = '0;
      end
    endcase
    soda_next   = (state_next == ST_VEND);
    change_next = (state_next == ST_CHANGE);
    busy_next   = (state_next != ST_COLLECT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_reg   <= '0;
      sold_cnt_reg <= '0;
      soda_reg     <= 1'b0;
      change_reg   <= 1'b0;
      reject_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      credit_reg   <= credit_next;
      sold_cnt_reg <= sold_cnt_next;
      soda_reg     <= soda_next;
      change_reg   <= change_next;
      reject_reg   <= reject_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.soda_o     = soda_reg;
  assign bus.change_o   = change_reg;
  assign bus.reject_o   = reject_reg;
  assign bus.busy_o     = busy_reg;
  assign bus.credit_o   = credit_reg;
  assign bus.sold_cnt_o = sold_cnt_reg;

endmodule

// File: tb/tb_soda_vend_n.sv
// Bench for soda_vend_n: three parameterisations driven cycle by cycle, expected
// outputs queued from a cents-level reference and compared after each edge.
module tb_soda_vend_n;

  typedef struct {
    int st;      // 0 collect, 1 vend, 2 change
    int credit;
    int sold;
    int price;
    int maxc;
    int cmod;
  } model_t;

  typedef struct {
    int dut;
    int soda;
    int change;
    int reject;
    int busy;
    int credit;
    int sold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ac;
  logic rst_b;

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;
  int soda_seen [3];
  int change_seen [3];
  model_t mdl [3];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  soda_vend_n_if #(.CREDIT_W(7), .CNT_W(8)) ifa ();
  soda_vend_n_if #(.CREDIT_W(7), .CNT_W(8)) ifb ();
  soda_vend_n_if #(.CREDIT_W(7), .CNT_W(2)) ifc ();

  soda_vend_n u_a (.clk_i(clk), .rst_i(rst_ac), .bus(ifa.slave));
  soda_vend_n #(.PRICE(25), .MAX_CREDIT(20)) u_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb.slave));
  soda_vend_n #(.CNT_W(2)) u_c (.clk_i(clk), .rst_i(rst_ac), .bus(ifc.slave));

  task automatic check_value(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, step_no);
    end
  endtask

  task automatic model_init(input int k, input int price, input int maxc, input int cmod);
    mdl[k].st     = 0;
    mdl[k].credit = 0;
    mdl[k].sold   = 0;
    mdl[k].price  = price;
    mdl[k].maxc   = maxc;
    mdl[k].cmod   = cmod;
  endtask

  task automatic model_step(input int k, input bit n, input bit d, input bit q, input bit c,
                            output exp_t e);
    int v;
    bit extra;
    bit any;
    int rej;
    any = n | d | q;
    rej = 0;
    v = 0;
    extra = 0;
    case (mdl[k].st)
      0: begin
        if (c && mdl[k].credit > 0) begin
          rej = any;
          mdl[k].st = 2;
        end else begin
          if (n) begin v = 5; extra = d | q; end
          else if (d) begin v = 10; extra = q; end
          else if (q) v = 25;
          if (v > 0) begin
            if (mdl[k].credit + v > mdl[k].maxc) rej = 1;
            else mdl[k].credit = mdl[k].credit + v;
          end
          if (extra) rej = 1;
          if (mdl[k].credit >= mdl[k].price) mdl[k].st = 1;
        end
      end
      1: begin
        rej = any;
        mdl[k].credit = mdl[k].credit - mdl[k].price;
        mdl[k].sold = (mdl[k].sold + 1) % mdl[k].cmod;
        mdl[k].st = (mdl[k].credit > 0) ? 2 : 0;
      end
      default: begin
        rej = any;
        mdl[k].credit = mdl[k].credit - 5;
        if (mdl[k].credit == 0) mdl[k].st = 0;
      end
    endcase
    e.dut    = k;
    e.soda   = (mdl[k].st == 1) ? 1 : 0;
    e.change = (mdl[k].st == 2) ? 1 : 0;
    e.busy   = (mdl[k].st != 0) ? 1 : 0;
    e.reject = rej;
    e.credit = mdl[k].credit;
    e.sold   = mdl[k].sold;
  endtask

  function automatic exp_t observe(input int k);
    exp_t o;
    o.dut = k;
    case (k)
      0: begin
        o.soda = int'(ifa.soda_o); o.change = int'(ifa.change_o); o.reject = int'(ifa.reject_o);
        o.busy = int'(ifa.busy_o); o.credit = int'(ifa.credit_o); o.sold = int'(ifa.sold_cnt_o);
      end
      1: begin
        o.soda = int'(ifb.soda_o); o.change = int'(ifb.change_o); o.reject = int'(ifb.reject_o);
        o.busy = int'(ifb.busy_o); o.credit = int'(ifb.credit_o); o.sold = int'(ifb.sold_cnt_o);
      end
      default: begin
        o.soda = int'(ifc.soda_o); o.change = int'(ifc.change_o); o.reject = int'(ifc.reject_o);
        o.busy = int'(ifc.busy_o); o.credit = int'(ifc.credit_o); o.sold = int'(ifc.sold_cnt_o);
      end
    endcase
    return o;
  endfunction

  task automatic drive(input int k, input bit n, input bit d, input bit q, input bit c);
    ifa.nickle_i = (k == 0) & n; ifa.dime_i = (k == 0) & d;
    ifa.quater_i = (k == 0) & q; ifa.cancel_i = (k == 0) & c;
    ifb.nickle_i = (k == 1) & n; ifb.dime_i = (k == 1) & d;
    ifb.quater_i = (k == 1) & q; ifb.cancel_i = (k == 1) & c;
    ifc.nickle_i = (k == 2) & n; ifc.dime_i = (k == 2) & d;
    ifc.quater_i = (k == 2) & q; ifc.cancel_i = (k == 2) & c;
  endtask

  // One clock: present inputs to DUT k (others idle), queue predictions, compare after the edge.
  task automatic step(input int k, input bit n, input bit d, input bit q, input bit c);
    exp_t e;
    exp_t o;
    drive(k, n, d, q, c);
    for (int j = 0; j < 3; j++) begin
      model_step(j, (j == k) & n, (j == k) & d, (j == k) & q, (j == k) & c, e);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    step_no++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.dut);
      check_value($sformatf("dut%0d.soda", e.dut), o.soda, e.soda);
      check_value($sformatf("dut%0d.change", e.dut), o.change, e.change);
      check_value($sformatf("dut%0d.reject", e.dut), o.reject, e.reject);
      check_value($sformatf("dut%0d.busy", e.dut), o.busy, e.busy);
      check_value($sformatf("dut%0d.credit", e.dut), o.credit, e.credit);
      check_value($sformatf("dut%0d.sold", e.dut), o.sold, e.sold);
      soda_seen[e.dut]   += o.soda;
      change_seen[e.dut] += o.change;
    end
    $display("step %0d dut%0d n=%0b d=%0b q=%0b c=%0b credit_a=%0d credit_b=%0d credit_c=%0d",
             step_no, k, n, d, q, c, ifa.credit_o, ifb.credit_o, ifc.credit_o);
  endtask

  task automatic clear_seen();
    for (int j = 0; j < 3; j++) begin
      soda_seen[j] = 0;
      change_seen[j] = 0;
    end
  endtask

  int sold_exp [4] = '{1, 2, 3, 0};

  initial begin
    rst_ac = 1'b1;
    rst_b  = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_init(0, 20, 60, 256);
    model_init(1, 25, 20, 256);
    model_init(2, 20, 60, 4);
    clear_seen();
    #12;
    check_value("rst.a.credit", int'(ifa.credit_o), 0);
    check_value("rst.a.busy", int'(ifa.busy_o), 0);
    check_value("rst.a.sold", int'(ifa.sold_cnt_o), 0);
    check_value("rst.b.soda", int'(ifb.soda_o), 0);
    check_value("rst.c.reject", int'(ifc.reject_o), 0);
    check_value("rst.c.change", int'(ifc.change_o), 0);
    rst_ac = 1'b0;
    rst_b  = 1'b0;

    // dime, dime: vend right after the second dime, no change
    clear_seen();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_value("t1.soda_now", int'(ifa.soda_o), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_value("t1.credit", int'(ifa.credit_o), 0);
    check_value("t1.sold", int'(ifa.sold_cnt_o), 1);
    check_value("t1.sodas", soda_seen[0], 1);
    check_value("t1.changes", change_seen[0], 0);

    // quarter: vend with 25 credit, one nickel back
    clear_seen();
    step(0, 0, 0, 1, 0);
    check_value("t2.soda_now", int'(ifa.soda_o), 1);
    check_value("t2.credit25", int'(ifa.credit_o), 25);
    step(0, 0, 0, 0, 0);
    check_value("t2.credit5", int'(ifa.credit_o), 5);
    step(0, 0, 0, 0, 0);
    check_value("t2.credit0", int'(ifa.credit_o), 0);
    check_value("t2.changes", change_seen[0], 1);

    // nickel+quarter together: nickel wins, quarter rejected
    clear_seen();
    step(0, 1, 0, 1, 0);
    check_value("t3.credit", int'(ifa.credit_o), 5);
    check_value("t3.reject", int'(ifa.reject_o), 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    check_value("t3.changes", change_seen[0], 2);
    check_value("t3.sold", int'(ifa.sold_cnt_o), 3);

    // nickel, dime, cancel: 15 cents refunded, no sale
    clear_seen();
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    check_value("t4.changes", change_seen[0], 3);
    check_value("t4.sodas", soda_seen[0], 0);
    check_value("t4.sold", int'(ifa.sold_cnt_o), 3);

    // overflow with MAX_CREDIT=20, then async reset in the middle of change
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    check_value("t5.reject", int'(ifb.reject_o), 1);
    check_value("t5.credit", int'(ifb.credit_o), 20);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_value("t5.busy_pre", int'(ifb.busy_o), 1);
    #2;
    rst_b = 1'b1;
    #1;
    check_value("t5.rst_credit", int'(ifb.credit_o), 0);
    check_value("t5.rst_change", int'(ifb.change_o), 0);
    check_value("t5.rst_busy", int'(ifb.busy_o), 0);
    model_init(1, 25, 20, 256);
    rst_b = 1'b0;
    step(1, 1, 0, 0, 0);
    check_value("t5.after_rst", int'(ifb.credit_o), 5);

    // CNT_W=2 wrap: sold count 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      step(2, 0, 1, 0, 0);
      step(2, 0, 1, 0, 0);
      step(2, 0, 0, 0, 0);
      check_value($sformatf("t6.sold%0d", i), int'(ifc.sold_cnt_o), sold_exp[i]);
    end
    // coin while busy is rejected and leaves credit alone
    step(2, 0, 0, 1, 0);
    step(2, 0, 1, 0, 0);
    check_value("t6.busy_reject", int'(ifc.reject_o), 1);
    check_value("t6.busy_credit", int'(ifc.credit_o), 5);
    step(2, 0, 0, 0, 0);
    check_value("t6.final_credit", int'(ifc.credit_o), 0);

    // random traffic on the default instance
    for (int i = 0; i < 150; i++) begin
      step(0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
